risc_ctrl_fsm: RTL
==================

# risc_ctrl_fsm

Multi-cycle control unit for the 16-bit RISC datapath; the producer side of the ALU's `alu_control`/`zero` interface. It sequences fetch, decode, execute, memory and writeback per instruction. It decodes the 4-bit opcode into `alu_control` and the datapath enables, and resolves branches from the ALU `zero` flag. It sits between the instruction/data memory handshake and the register file/PC/ALU datapath.

## Interface
Parameters:
- `OPW`, 4: opcode width, `instr[15:12]`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `instr` in 16: instruction word from memory; valid when `mem_ready`=1 during FETCH.
- `zero` in 1: ALU zero flag; sampled in EXECUTE.
- `mem_ready` in 1: memory completion strobe for the current read or write.
- `mem_read` out 1: memory read request, held until `mem_ready`.
- `mem_write` out 1: memory write request, held until `mem_ready`.
- `ir_write` out 1: latch `instr` into the instruction register.
- `pc_write` out 1: update the PC.
- `pc_src` out 1: 0 = PC+1, 1 = branch/jump target.
- `reg_write` out 1: register-file write enable.
- `wb_sel` out 1: 0 = ALU result, 1 = memory data.
- `alu_control` out 4: ALU function select.
- `halted` out 1: core stopped.
- `instr_count` out 16: retired instruction count; present only with `INSTR_COUNT_EN`.

## Operation
- Opcodes 0000–1000 are ALU ops (ADD, SUB, NOT, SHL, SHR, AND, OR, INC, DEC). For these, `alu_control` equals the opcode.
- Other opcodes: 1001 LOAD, 1010 STORE, 1011 BEQ, 1100 BNE, 1101 JMP, 1110 NOP, 1111 HALT.
- LOAD and STORE drive `alu_control`=0000 (address add). BEQ and BNE drive 0001 (compare subtract). All other states and opcodes drive 0000.
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- FETCH: `mem_read`=1. On `mem_ready`, pulse `ir_write`, pulse `pc_write` with `pc_src`=0, go to DECODE. Otherwise stay in FETCH.
- DECODE: one cycle. HALT opcode → HALT. NOP → FETCH (retires). All others → EXECUTE.
- EXECUTE:
  - ALU op → WB.
  - LOAD or STORE → MEM.
  - BEQ: if `zero`=1, `pc_write`=1 and `pc_src`=1. Go to FETCH.
  - BNE: if `zero`=0, `pc_write`=1 and `pc_src`=1. Go to FETCH.
  - JMP: unconditional `pc_write`=1, `pc_src`=1. Go to FETCH.
- MEM:
  - LOAD holds `mem_read`=1; STORE holds `mem_write`=1.
  - On `mem_ready`: LOAD → WB; STORE → FETCH (retires).
- WB: `reg_write`=1 for one cycle. `wb_sel`=1 for LOAD, 0 for ALU ops. Go to FETCH (retires).
- HALT: absorbing; `halted`=1; all enables 0. Only `rst` exits.
- The opcode is held in a register captured with `ir_write`. Control decisions never use `instr` outside FETCH.
- All outputs are decoded from the state register and the held opcode. No output depends combinationally on `mem_ready` except the FETCH `ir_write`/`pc_write` pulses and the MEM exit.

## Timing
- Reset, synchronous: state=FETCH, held opcode=NOP, `instr_count`=0. All outputs 0 in the reset cycle.
- First `mem_read` is asserted in the cycle after `rst` deasserts.
- Cycle counts with `mem_ready` answered in the same cycle:
  - ALU op: 4 (F, D, E, W).
  - LOAD: 5.
  - STORE: 4.
  - Branch or JMP: 3.
  - NOP: 2.
- Each cycle without `mem_ready` adds one cycle in FETCH or MEM.
- `mem_read` and `mem_write` are never both 1.
- `rst` asserted in any state, including mid-MEM wait, returns to FETCH next edge. The outstanding request is dropped.
- `instr_count` increments on the cycle of the transition that retires an instruction. It wraps 0xFFFF → 0x0000. HALT does not count.

## Configuration
- `RISC_INSTR_COUNT_EN` defined: the 16-bit retired-instruction counter and the `instr_count` port exist.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `risc_pkg`:
  - state enum `ctrl_state_t`;
  - opcode localparams `OP_ADD` … `OP_HALT`;
  - ALU function localparams `ALU_ADD` … `ALU_DEC`;
  - these are shared with the ALU.
- One combinational sub-module `risc_op_decode`: held opcode → `alu_control`, `is_alu`, `is_load`, `is_store`, `is_branch`, `is_jmp`.
- Immediate assertion in the FSM: `!$isunknown({state, opcode})` every cycle out of reset.

## Test plan
- Reset then ADD (`instr`=0x0000), `mem_ready` tied 1 → FETCH, DECODE, EXECUTE, WB over 4 cycles. `alu_control`=0000 in EXECUTE; `reg_write`=1 only in WB.
- LOAD (0x9000), `mem_ready` low 3 cycles in MEM → `mem_read` held 4 cycles in MEM, `wb_sel`=1, total 8 cycles.
- BEQ (0xB000) with `zero`=1 → `pc_write`=1, `pc_src`=1 in EXECUTE. Repeat with `zero`=0 → no `pc_write` in EXECUTE. Repeat both cases for BNE (0xC000) → inverse behaviour.
- SUB (0x1000) → `alu_control`=0001. DEC (0x8000) → 1000. STORE (0xA000) → `mem_write`=1 in MEM and never `reg_write`.
- HALT (0xF000) → `halted`=1 held for 20 cycles with all enables 0. `rst` → FETCH with `halted`=0.
- `RISC_INSTR_COUNT_EN`: preload to 0xFFFE via 2 ops after forced state, execute 3 NOPs → count 0xFFFF, 0x0000, 0x0001. `rst` mid-MEM → count 0 and state FETCH next cycle.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared RISC definitions: control FSM states, opcodes and ALU function codes.
// Used by the control FSM, its opcode decoder and the ALU.
package risc_pkg;

  localparam int ALUW = 4;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd5
  } ctrl_state_t;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_NOT   = 4'h2;
  localparam logic [3:0] OP_SHL   = 4'h3;
  localparam logic [3:0] OP_SHR   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_INC   = 4'h7;
  localparam logic [3:0] OP_DEC   = 4'h8;
  localparam logic [3:0] OP_LOAD  = 4'h9;
  localparam logic [3:0] OP_STORE = 4'hA;
  localparam logic [3:0] OP_BEQ   = 4'hB;
  localparam logic [3:0] OP_BNE   = 4'hC;
  localparam logic [3:0] OP_JMP   = 4'hD;
  localparam logic [3:0] OP_NOP   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [ALUW-1:0] ALU_ADD = 4'h0;
  localparam logic [ALUW-1:0] ALU_SUB = 4'h1;
  localparam logic [ALUW-1:0] ALU_NOT = 4'h2;
  localparam logic [ALUW-1:0] ALU_SHL = 4'h3;
  localparam logic [ALUW-1:0] ALU_SHR = 4'h4;
  localparam logic [ALUW-1:0] ALU_AND = 4'h5;
  localparam logic [ALUW-1:0] ALU_OR  = 4'h6;
  localparam logic [ALUW-1:0] ALU_INC = 4'h7;
  localparam logic [ALUW-1:0] ALU_DEC = 4'h8;

endpackage

// File: rtl/risc_ctrl_fsm_if.sv
// Control-unit bus: memory handshake, instruction/zero inputs and datapath enables.
// instr_count exists only when RISC_INSTR_COUNT_EN is defined.
interface risc_ctrl_fsm_if;
  import risc_pkg::*;

  logic [15:0]     instr;
  logic            zero;
  logic            mem_ready;
  logic            mem_read;
  logic            mem_write;
  logic            ir_write;
  logic            pc_write;
  logic            pc_src;
  logic            reg_write;
  logic            wb_sel;
  logic [ALUW-1:0] alu_control;
  logic            halted;
`ifdef RISC_INSTR_COUNT_EN
  logic [15:0]     instr_count;

  modport master (
    input  instr, zero, mem_ready,
    output mem_read, mem_write, ir_write, pc_write, pc_src,
           reg_write, wb_sel, alu_control, halted, instr_count
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_read, mem_write, ir_write, pc_write, pc_src,
           reg_write, wb_sel, alu_control, halted, instr_count
  );
`else
  modport master (
    input  instr, zero, mem_ready,
    output mem_read, mem_write, ir_write, pc_write, pc_src,
           reg_write, wb_sel, alu_control, halted
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_read, mem_write, ir_write, pc_write, pc_src,
           reg_write, wb_sel, alu_control, halted
  );
`endif

endinterface

// File: rtl/risc_op_decode.sv
// Combinational opcode decoder: held opcode to ALU function and instruction class.
module risc_op_decode
  import risc_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0]  opcode,
  output logic [ALUW-1:0] alu_control,
  output logic            is_alu,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_jmp
);

  always_comb begin
    alu_control = ALU_ADD;
    is_alu      = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_branch   = 1'b0;
    is_jmp      = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_NOT, OP_SHL, OP_SHR,
      OP_AND, OP_OR, OP_INC, OP_DEC: begin
        alu_control = opcode;
        is_alu      = 1'b1;
      end
      OP_LOAD:  is_load  = 1'b1;
      OP_STORE: is_store = 1'b1;
      OP_BEQ, OP_BNE: begin
        alu_control = ALU_SUB;
        is_branch   = 1'b1;
      end
      OP_JMP:   is_jmp   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/risc_ctrl_fsm.sv
// Multi-cycle control FSM for the 16-bit RISC core (fetch/decode/execute/mem/wb/halt).
// Optional retired-instruction counter enabled by RISC_INSTR_COUNT_EN.
module risc_ctrl_fsm
  import risc_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic            clk,
  input  logic            rst,
  risc_ctrl_fsm_if.master bus
);

  ctrl_state_t     state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;

  logic [ALUW-1:0] dec_alu;
  logic            is_alu, is_load, is_store, is_branch, is_jmp;
  logic            br_taken;
  logic            unused_instr_bits;

  risc_op_decode #(.OPW(OPW)) u_dec (
    .opcode      (op_q),
    .alu_control (dec_alu),
    .is_alu      (is_alu),
    .is_load     (is_load),
    .is_store    (is_store),
    .is_branch   (is_branch),
    .is_jmp      (is_jmp)
  );

  assign unused_instr_bits = ^bus.instr[15-OPW:0];

  assign br_taken = is_jmp |
                    (is_branch & ((op_q == OP_BEQ) ? bus.zero : ~bus.zero));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_FETCH: if (bus.mem_ready) begin
        state_d = ST_DECODE;
        op_d    = bus.instr[15 -: OPW];
      end
      ST_DECODE: begin
        if (op_q == OP_HALT)     state_d = ST_HALT;
        else if (op_q == OP_NOP) state_d = ST_FETCH;
        else                     state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (is_alu)                    state_d = ST_WB;
        else if (is_load || is_store)  state_d = ST_MEM;
        else                           state_d = ST_FETCH;
      end
      ST_MEM: if (bus.mem_ready) state_d = is_load ? ST_WB : ST_FETCH;
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Outputs are forced low while rst is high so the reset cycle is quiet
  // even before the state register has been initialised.
  logic            mem_read, mem_write, ir_write, pc_write, pc_src;
  logic            reg_write, wb_sel, halted;
  logic [ALUW-1:0] alu_control;

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 1'b0;
    halted      = 1'b0;
    alu_control = ALU_ADD;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_read = 1'b1;
          ir_write = bus.mem_ready;
          pc_write = bus.mem_ready;
        end
        ST_EXECUTE: begin
          alu_control = dec_alu;
          pc_write    = br_taken;
          pc_src      = br_taken;
        end
        ST_MEM: begin
          mem_read  = is_load;
          mem_write = is_store;
        end
        ST_WB: begin
          reg_write = 1'b1;
          wb_sel    = is_load;
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.ir_write    = ir_write;
  assign bus.pc_write    = pc_write;
  assign bus.pc_src      = pc_src;
  assign bus.reg_write   = reg_write;
  assign bus.wb_sel      = wb_sel;
  assign bus.halted      = halted;
  assign bus.alu_control = alu_control;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      op_q    <= OP_NOP;
    end else begin
      assert (!$isunknown({state_q, op_q}));
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

`ifdef RISC_INSTR_COUNT_EN
  logic        retire;
  logic [15:0] cnt_q, cnt_d;

  assign retire = ((state_q == ST_DECODE)  && (op_q == OP_NOP)) ||
                  ((state_q == ST_EXECUTE) && (is_branch || is_jmp)) ||
                  ((state_q == ST_MEM)     && is_store && bus.mem_ready) ||
                  (state_q == ST_WB);

  assign cnt_d = retire ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.instr_count = cnt_q;
`else
  // Counter absent: retirement is not tracked.
`endif

endmodule
